// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared CPU pipeline defaults
// Default pipeline depth, PC width and reset PC used by the pipe_ctrl slice.
package pipe_ctrl_pkg;

  localparam int          DEFAULT_STAGES = 5;
  localparam int          DEFAULT_PC_W   = 32;
  localparam logic [31:0] RESET_PC       = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline stage register (valid + pc)
// Kill clears only the valid bit and wins over a simultaneous load.
module pipe_stage_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_en,
  input  logic            kill,
  input  logic            valid_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            valid_out,
  output logic [PC_W-1:0] pc_out
);

  logic            valid_d, valid_q;
  logic [PC_W-1:0] pc_d, pc_q;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (kill) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      valid_d = valid_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      pc_q    <= PC_W'(RESET_PC);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = pc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - valid/allowin handshake pipeline controller
// Back-pressure chain, flush of younger stages and retire counting for a STAGES-deep pipe.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = DEFAULT_STAGES,
  parameter int PC_W   = DEFAULT_PC_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       in_allowin,
  input  logic [STAGES-1:0]          ready_go,
  input  logic                       flush,
  input  logic [$clog2(STAGES)-1:0]  flush_src,
  input  logic                       out_allowin,
  output logic [STAGES-1:0]          stage_valid,
  output logic [STAGES*PC_W-1:0]     stage_pc,
  output logic [STAGES-1:0]          stage_allowin,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                retire_cnt
);

  logic [STAGES-1:0]           valid;
  logic [STAGES-1:0][PC_W-1:0] pc;
  logic [STAGES-1:0]           allowin;
  logic [STAGES-1:0]           src_valid;
  logic [STAGES-1:0][PC_W-1:0] src_pc;
  logic [STAGES-1:0]           kill;
  logic [31:0]                 retire_cnt_d, retire_cnt_q;

  // Walk from the sink backwards; acc carries allowin of the next-older stage.
  always_comb begin : allowin_chain
    logic acc;
    allowin = '0;
    acc     = out_allowin;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc        = !valid[i] | (ready_go[i] & acc);
      allowin[i] = acc;
    end
  end

  always_comb begin
    src_valid = '0;
    src_pc    = '0;
    kill      = '0;
    src_valid[0] = in_valid & ~flush;
    src_pc[0]    = in_pc;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid[i-1] & ready_go[i-1];
      src_pc[i]    = pc[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      kill[i] = flush & (int'(flush_src) > i);
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_stage_reg #(
      .PC_W(PC_W)
    ) u_reg (
      .clk      (clk),
      .resetn   (resetn),
      .load_en  (allowin[i]),
      .kill     (kill[i]),
      .valid_in (src_valid[i]),
      .pc_in    (src_pc[i]),
      .valid_out(valid[i]),
      .pc_out   (pc[i])
    );
  end

  assign out_valid = valid[STAGES-1] & ready_go[STAGES-1] & out_allowin;
  assign out_pc    = pc[STAGES-1];

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (out_valid) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) retire_cnt_q <= 32'd0;
    else         retire_cnt_q <= retire_cnt_d;
  end

  assign in_allowin    = allowin[0];
  assign stage_allowin = allowin;
  assign stage_valid   = valid;
  assign stage_pc      = pc;
  assign retire_cnt    = retire_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, meaning number of pipeline stages (legal 2..8).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width carried per stage.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_pc  input  PC_W  PC of the presented instruction.
REQ-007 SHALL have port in_allowin  output  1  stage 0 accepts this cycle.
REQ-008 SHALL have port ready_go  input  STAGES  per-stage "work done" (0 = busy, e.g. divider or load-use stall).
REQ-009 SHALL have port flush  input  1  kill younger stages.
REQ-010 SHALL have port flush_src  input  $clog2(STAGES)  index of the stage raising flush.
REQ-011 SHALL have port out_allowin  input  1  retire sink accepts.
REQ-012 SHALL have port stage_valid  output  STAGES  per-stage valid bits.
REQ-013 SHALL have port stage_pc  output  STAGES*PC_W  per-stage PC, stage i at bits [i*PC_W +: PC_W].
REQ-014 SHALL have port stage_allowin  output  STAGES  per-stage allowin.
REQ-015 SHALL have port out_valid  output  1  last stage retiring this cycle.
REQ-016 SHALL have port out_pc  output  PC_W  PC of the retiring instruction (debug_wb_pc source).
REQ-017 SHALL have port retire_cnt  output  32  retired-instruction counter.

Function
REQ-018 SHALL compute allowin[i] = !valid[i] | (ready_go[i] & allowin[i+1]), with allowin[STAGES] = out_allowin; purely combinational.
REQ-019 SHALL drive in_allowin = allowin[0].
REQ-020 SHALL, when allowin[i] is 1, load valid[i] <= (valid[i-1] & ready_go[i-1]) and pc[i] <= pc[i-1]; for stage 0 the source is in_valid/in_pc.
REQ-021 SHALL hold valid[i] and pc[i] unchanged when allowin[i] is 0.
REQ-022 SHALL drive out_valid = valid[STAGES-1] & ready_go[STAGES-1] & out_allowin, and out_pc = pc[STAGES-1].
REQ-023 SHALL give one-cycle latency per stage: an instruction accepted at edge N with no stalls retires combinationally in the cycle after edge N+STAGES-1.
REQ-024 SHALL, on flush, clear valid[0..flush_src-1] at the next edge and ignore in_valid that cycle; stage flush_src and older SHALL advance per REQ-020.
REQ-025 SHALL give flush priority over advance for killed stages; flush with flush_src = 0 SHALL only block the stage-0 load.
REQ-026 SHALL not clear pc[i] on flush; only valid is cleared.
REQ-027 SHALL increment retire_cnt by 1 on each edge where out_valid = 1, wrapping 0xFFFFFFFF -> 0.
REQ-028 SHALL, with ready_go[k] = 0 and valid[k] = 1, hold stages 0..k and let stages >k drain, inserting bubbles (valid = 0) at k+1.

Reset
REQ-029 SHALL, while resetn = 0, force all valid to 0, all pc to 0, retire_cnt to 0, hence out_valid = 0.
REQ-030 SHALL, on reset assertion mid-operation, discard all in-flight instructions immediately without waiting for a clock.
REQ-031 SHALL accept in_valid at the first rising edge after resetn deasserts.

Structure
REQ-032 SHALL place default STAGES, PC_W and the reset PC value (0) in the shared CPU package.
REQ-033 SHALL instantiate one sub-module pipe_stage_reg per stage (valid + pc register, load enable, kill input), generated STAGES times.

Verification
REQ-034 SHALL cover: STAGES=5, in_valid=1 with PCs 0xBFC00000, +4, +8, all ready_go=1 -> out_pc 0xBFC00000 in cycle 5, then one per cycle; retire_cnt=3 after.
REQ-035 SHALL cover: ready_go[2]=0 for 3 cycles with all stages valid -> stages 0..2 hold, stage 3 valid=0 for 3 cycles, in_allowin=0 for 3 cycles.
REQ-036 SHALL cover: flush=1, flush_src=1 with stages 0..4 valid -> next cycle valid = 5'b11110 (stage 0 cleared), and the in_pc presented that cycle is not loaded.
REQ-037 SHALL cover: out_allowin=0 for 2 cycles on a full pipe -> in_allowin=0, no valid or pc changes, retire_cnt unchanged.
REQ-038 SHALL cover: retire_cnt preset via forced run to 0xFFFFFFFF, one retire -> 0x00000000.
REQ-039 SHALL cover: resetn pulsed low between edges mid-stream -> stage_valid=0 and retire_cnt=0 immediately; first post-reset PC retires STAGES cycles later.
